// File: rtl/seq_bit_serializer_pkg.sv
// Shared types and frame-length helper for seq_bit_serializer.
// Build option: define SER_PARITY_EN to append an even-parity bit to every frame.
package seq_det_pkg;

    typedef enum logic [0:0] {
        SER_IDLE  = 1'b0,
        SER_SHIFT = 1'b1
    } ser_state_e;

`ifdef SER_PARITY_EN
    localparam bit SER_PARITY_ON = 1'b1;
`else
    localparam bit SER_PARITY_ON = 1'b0;
`endif

    function automatic int ser_frame_len(input int width, input bit parity_en);
        return parity_en ? width + 1 : width;
    endfunction

endpackage

// File: rtl/seq_bit_serializer_if.sv
// Parallel-in handshake plus serial-out bundle for seq_bit_serializer.
// The slave modport is the serializer side; master is the word source / bit consumer.
interface seq_bit_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             out_bit;
    logic             out_valid;
    logic             busy;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  out_bit,
        input  out_valid,
        input  busy
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output out_bit,
        output out_valid,
        output busy
    );
endinterface

// File: rtl/seq_bit_serializer_hold_buf.sv
// One-entry holding register between the word source and the serializer shifter.
// in_ready is registered as !hold_full of the next state, so it never depends on in_valid.
module ser_hold_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             drain,
    output logic [WIDTH-1:0] hold_data,
    output logic             hold_full
);

    logic [WIDTH-1:0] hold_reg;
    logic             hold_full_reg;
    logic             hold_full_next;
    logic             in_ready_reg;
    logic             accept;

    assign accept = in_valid & in_ready_reg;

    // Accept needs an empty buffer and drain needs a full one, so they never coincide.
    always_comb begin
        hold_full_next = hold_full_reg;
        if (accept) begin
            hold_full_next = 1'b1;
        end else if (drain) begin
            hold_full_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_full_reg <= 1'b0;
            in_ready_reg  <= 1'b0;
        end else begin
            hold_full_reg <= hold_full_next;
            in_ready_reg  <= !hold_full_next;
        end
        if (accept) begin
            hold_reg <= in_data;
        end
    end

    assign in_ready  = in_ready_reg;
    assign hold_data = hold_reg;
    assign hold_full = hold_full_reg;

endmodule

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial feeder: one-word holding buffer, shifter FSM, registered serial output.
// Build option: SER_PARITY_EN appends an even-parity bit (frame = WIDTH+1).
module seq_bit_serializer
    import seq_det_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input logic                 clk,
    input logic                 rst,
    seq_bit_serializer_if.slave bus
);

    localparam int FRAME = ser_frame_len(WIDTH, SER_PARITY_ON);
    localparam int CNT_W = $clog2(FRAME);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME - 1);

    ser_state_e       state_reg;
    logic [CNT_W-1:0] bit_cnt_reg;
    logic [FRAME-1:0] shift_reg;
    logic [FRAME-1:0] load_frame;
    logic             out_bit_reg;
    logic             out_valid_reg;

    logic [WIDTH-1:0] hold_data;
    logic             hold_full;
    logic             in_ready;
    logic             drain;

    ser_hold_buf #(
        .WIDTH(WIDTH)
    ) u_hold_buf (
        .clk      (clk),
        .rst      (rst),
        .in_data  (bus.in_data),
        .in_valid (bus.in_valid),
        .in_ready (in_ready),
        .drain    (drain),
        .hold_data(hold_data),
        .hold_full(hold_full)
    );

    // load_frame[0] is the first bit put on the wire.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_order
            if (MSB_FIRST) begin : g_msb
                assign load_frame[gi] = hold_data[WIDTH-1-gi];
            end else begin : g_lsb
                assign load_frame[gi] = hold_data[gi];
            end
        end
    endgenerate

`ifdef SER_PARITY_EN
    assign load_frame[WIDTH] = ^hold_data;
`endif

    // Reload happens from idle or on the last visible bit, giving gapless frames.
    assign drain = hold_full &
                   ((state_reg == SER_IDLE) | (bit_cnt_reg == LAST_CNT));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= SER_IDLE;
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            out_bit_reg   <= IDLE_BIT;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                SER_IDLE: begin
                    if (drain) begin
                        state_reg     <= SER_SHIFT;
                        bit_cnt_reg   <= '0;
                        out_bit_reg   <= load_frame[0];
                        out_valid_reg <= 1'b1;
                        shift_reg     <= load_frame >> 1;
                    end else begin
                        out_bit_reg   <= IDLE_BIT;
                        out_valid_reg <= 1'b0;
                    end
                end
                SER_SHIFT: begin
                    if (bit_cnt_reg != LAST_CNT) begin
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                        out_bit_reg <= shift_reg[0];
                        shift_reg   <= shift_reg >> 1;
                    end else if (drain) begin
                        bit_cnt_reg   <= '0;
                        out_bit_reg   <= load_frame[0];
                        out_valid_reg <= 1'b1;
                        shift_reg     <= load_frame >> 1;
                    end else begin
                        state_reg     <= SER_IDLE;
                        bit_cnt_reg   <= '0;
                        out_bit_reg   <= IDLE_BIT;
                        out_valid_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg     <= SER_IDLE;
                    bit_cnt_reg   <= '0;
                    out_bit_reg   <= IDLE_BIT;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_bit   = out_bit_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.busy      = (state_reg == SER_SHIFT) | hold_full;

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Directed bench for seq_bit_serializer (WIDTH=8, MSB first, idle level 0).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_seq_bit_serializer;
    import seq_det_pkg::*;

    localparam int W  = 8;
    localparam int FR = ser_frame_len(W, SER_PARITY_ON);

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   vcnt, run, max_run;
    logic cap_q[$];
    logic exp_q[$];

    seq_bit_serializer_if #(.WIDTH(W)) bus ();

    seq_bit_serializer #(
        .WIDTH    (W),
        .MSB_FIRST(1'b1),
        .IDLE_BIT (1'b0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (bus.out_valid === 1'b1) begin
            cap_q.push_back(bus.out_bit);
            vcnt++;
            run++;
            if (run > max_run) max_run = run;
        end else begin
            run = 0;
        end
    endtask

    task automatic clr_cap();
        cap_q.delete();
        exp_q.delete();
        vcnt    = 0;
        run     = 0;
        max_run = 0;
    endtask

    task automatic add_exp(input logic [7:0] w);
        for (int i = W - 1; i >= 0; i--) exp_q.push_back(w[i]);
`ifdef SER_PARITY_EN
        exp_q.push_back(^w);
`endif
    endtask

    task automatic chk_stream(input string tag);
        chk({tag, "_len"}, cap_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
            chk($sformatf("%s_bit%0d", tag, i), cap_q[i], exp_q[i]);
    endtask

    logic [7:0] words [3];
    logic [7:0] b4;
    logic [8:0] packed_bits;
    int   idx, toggles;
    logic acc, prev_rdy;

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        clr_cap();

        // Reset held for two cycles
        rst = 1'b1;
        tick();
        tick();
        chk("reset_out_valid", bus.out_valid, 1'b0);
        chk("reset_out_bit",   bus.out_bit,   1'b0);
        chk("reset_busy",      bus.busy,      1'b0);
        chk("reset_in_ready",  bus.in_ready,  1'b0);
        rst = 1'b0;
        tick();
        chk("release_in_ready", bus.in_ready,  1'b1);
        chk("release_out_valid", bus.out_valid, 1'b0);

        // Single word 8'hB4 with exact cycle timing
        clr_cap();
        b4 = 8'hB4;
        bus.in_data  = b4;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk("single_busy_after_accept", bus.busy,      1'b1);
        chk("single_no_bit_yet",        bus.out_valid, 1'b0);
        chk("single_ready_low",         bus.in_ready,  1'b0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("single_valid%0d", i), bus.out_valid, 1'b1);
            chk($sformatf("single_bit%0d", i),   bus.out_bit,   b4[7-i]);
        end
`ifdef SER_PARITY_EN
        tick();
        chk("single_parity_valid", bus.out_valid, 1'b1);
        chk("single_parity_bit",   bus.out_bit,   1'b0);
`endif
        tick();
        chk("single_end_valid", bus.out_valid, 1'b0);
        chk("single_end_bit",   bus.out_bit,   1'b0);
        chk("single_end_busy",  bus.busy,      1'b0);
        chk("single_end_ready", bus.in_ready,  1'b1);

        // Back-to-back words with in_valid held high
        clr_cap();
        words[0] = 8'hFF;
        words[1] = 8'h00;
        words[2] = 8'hA5;
        add_exp(words[0]);
        add_exp(words[1]);
        add_exp(words[2]);
        idx = 0;
        toggles = 0;
        prev_rdy = bus.in_ready;
        bus.in_data  = words[0];
        bus.in_valid = 1'b1;
        acc = bus.in_ready;
        for (int c = 0; c < 60; c++) begin
            tick();
            if (acc) idx++;
            if (idx < 3) begin
                bus.in_valid = 1'b1;
                bus.in_data  = words[idx];
            end else begin
                bus.in_valid = 1'b0;
            end
            if (bus.in_ready !== prev_rdy) toggles++;
            prev_rdy = bus.in_ready;
            acc = bus.in_valid & bus.in_ready;
        end
        chk("b2b_words_taken", idx,     3);
        chk("b2b_valid_cycles", vcnt,   3 * FR);
        chk("b2b_longest_run", max_run, 3 * FR);
        chk("b2b_ready_toggled", (toggles >= 2), 1'b1);
        chk_stream("b2b");
        chk("b2b_idle_busy", bus.busy, 1'b0);

        // Backpressure: second word waits until in_ready returns
        clr_cap();
        add_exp(8'h11);
        add_exp(8'h22);
        bus.in_data  = 8'h11;
        bus.in_valid = 1'b1;
        tick();
        bus.in_data = 8'h22;
        chk("bp_ready_low", bus.in_ready, 1'b0);
        chk("bp_busy",      bus.busy,     1'b1);
        tick();
        chk("bp_ready_back", bus.in_ready, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        chk("bp_taken_ready_low", bus.in_ready, 1'b0);
        chk("bp_taken_busy",      bus.busy,     1'b1);
        repeat (30) tick();
        chk_stream("bp");

        // Reset in mid-frame with a second word held
        clr_cap();
        bus.in_data  = 8'hC3;
        bus.in_valid = 1'b1;
        tick();
        bus.in_data = 8'h5A;
        tick();
        tick();
        bus.in_valid = 1'b0;
        chk("mid_word_held", bus.in_ready, 1'b0);
        tick();
        chk("mid_bits_seen", cap_q.size(), 3);
        packed_bits = '0;
        for (int i = 0; i < cap_q.size() && i < 3; i++)
            packed_bits = {packed_bits[7:0], cap_q[i]};
        chk("mid_first_bits", packed_bits, 9'b110);
        rst = 1'b1;
        tick();
        chk("mid_rst_valid", bus.out_valid, 1'b0);
        chk("mid_rst_busy",  bus.busy,      1'b0);
        chk("mid_rst_bit",   bus.out_bit,   1'b0);
        chk("mid_rst_ready", bus.in_ready,  1'b0);
        rst = 1'b0;
        clr_cap();
        repeat (25) tick();
        chk("mid_no_resume", vcnt, 0);
        chk("mid_ready_after", bus.in_ready, 1'b1);

`ifdef SER_PARITY_EN
        // Parity frames: 8'h07 -> parity 1, 8'h03 -> parity 0
        clr_cap();
        bus.in_data  = 8'h07;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (12) tick();
        chk("par07_len", cap_q.size(), 9);
        packed_bits = '0;
        for (int i = 0; i < cap_q.size() && i < 9; i++)
            packed_bits = {packed_bits[7:0], cap_q[i]};
        chk("par07_bits", packed_bits, 9'b000001111);

        clr_cap();
        bus.in_data  = 8'h03;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (12) tick();
        chk("par03_len", cap_q.size(), 9);
        packed_bits = '0;
        for (int i = 0; i < cap_q.size() && i < 9; i++)
            packed_bits = {packed_bits[7:0], cap_q[i]};
        chk("par03_bits", packed_bits, 9'b000000110);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
